// File: rtl/adder_pipe.sv
// Chunked ripple-carry adder pipeline with per-stage valid/ready flow control.
// Define ADDER_PIPE_SAT_EN for unsigned saturation of sum_o on carry-out.
module adder_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  localparam int unsigned C = WIDTH / STAGES;

  logic [STAGES-1:0] vld_q, vld_d, adv;
  logic [STAGES-1:0] cy_q, cy_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];

  function automatic logic [C:0] add_chunk(input logic [C-1:0] x,
                                           input logic [C-1:0] y,
                                           input logic         c);
    return {1'b0, x} + {1'b0, y} + {{C{1'b0}}, c};
  endfunction

  // A stage moves when it is empty or its successor moves, so bubbles collapse.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !vld_q[STAGES-1] || ready_i;
    for (int unsigned i = 1; i < STAGES; i++) begin
      adv[STAGES-1-i] = !vld_q[STAGES-1-i] || adv[STAGES-i];
    end
  end

  always_comb begin
    logic [C:0] t;
    vld_d = '0;
    cy_d  = '0;
    t     = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      a_d[k]   = '0;
      b_d[k]   = '0;
      sum_d[k] = '0;
    end

    t           = add_chunk(a_i[C-1:0], b_i[C-1:0], cin_i);
    vld_d[0]    = valid_i;
    a_d[0]      = a_i;
    b_d[0]      = b_i;
    sum_d[0][C-1:0] = t[C-1:0];
    cy_d[0]     = t[C];

    // Operands ride along unchanged; each stage fills in its own sum chunk.
    for (int unsigned k = 1; k < STAGES; k++) begin
      t        = add_chunk(a_q[k-1][k*C +: C], b_q[k-1][k*C +: C], cy_q[k-1]);
      vld_d[k] = vld_q[k-1];
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      sum_d[k] = sum_q[k-1];
      sum_d[k][k*C +: C] = t[C-1:0];
      cy_d[k]  = t[C];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      cy_q  <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          vld_q[k] <= vld_d[k];
          cy_q[k]  <= cy_d[k];
          a_q[k]   <= a_d[k];
          b_q[k]   <= b_d[k];
          sum_q[k] <= sum_d[k];
        end
      end
    end
  end

  assign ready_o = adv[0];
  assign valid_o = vld_q[STAGES-1];
  assign carry_o = cy_q[STAGES-1];

`ifdef ADDER_PIPE_SAT_EN
  assign sum_o = cy_q[STAGES-1] ? '1 : sum_q[STAGES-1];
`else
  assign sum_o = sum_q[STAGES-1];
`endif

endmodule
